// File: rtl/frame_burst_sched.sv
// frame_burst_sched: per-frame burst request sequencer for the frame address generator.
// It issues one new_base pulse per frame. Each line then gets line_bursts full-burst
// requests and an optional tail request. Every request is held until it is acknowledged
// and is followed by REQ_GAP low cycles.
// Optional build macro FRAME_SCHED_ABORT_EN adds the abort input and the frame_aborted output.
module frame_burst_sched #(
  parameter int LSIZE   = 16,
  parameter int BSIZE   = 12,
  parameter int TSIZE   = 8,
  parameter int REQ_GAP = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [LSIZE-1:0] vsize,
  input  logic [BSIZE-1:0] line_bursts,
  input  logic [TSIZE-1:0] tail_len,
  output logic             new_base,
  output logic             burst_req,
  input  logic             burst_ack,
  output logic             tail_req,
  input  logic             tail_ack,
  output logic [TSIZE-1:0] tail_beats,
  output logic             busy,
`ifdef FRAME_SCHED_ABORT_EN
  input  logic             abort,
  output logic             frame_aborted,
`endif
  output logic             frame_done
);

  localparam int GW = (REQ_GAP > 1) ? $clog2(REQ_GAP) : 1;
  localparam logic [GW-1:0] GapLast = GW'(REQ_GAP - 1);

  typedef enum logic [2:0] {IDLE, BASE, BURST, TAIL, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [BSIZE-1:0] burstCnt_q, burstCnt_d;
  logic [LSIZE-1:0] lineCnt_q, lineCnt_d;
  logic [LSIZE-1:0] lineNext;
  logic             tailDone_q, tailDone_d;
  logic [GW-1:0]    gapCnt_q, gapCnt_d;
  logic [LSIZE-1:0] vsize_q, vsize_d;
  logic [BSIZE-1:0] lineBursts_q, lineBursts_d;
  logic [TSIZE-1:0] tailLen_q, tailLen_d;
  logic             newBase_q, newBase_d;
  logic             burstReq_q, burstReq_d;
  logic             tailReq_q, tailReq_d;
  logic             busy_q, busy_d;
  logic             frameDone_q, frameDone_d;
`ifdef FRAME_SCHED_ABORT_EN
  logic             abortFlag_q, abortFlag_d;
  logic             abortSeen;
  logic             frameAborted_q, frameAborted_d;
`endif

  assign lineNext = lineCnt_q + LSIZE'(1);

  // State register, counters, latched frame parameters and registered outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      burstCnt_q   <= '0;
      lineCnt_q    <= '0;
      tailDone_q   <= 1'b0;
      gapCnt_q     <= '0;
      vsize_q      <= '0;
      lineBursts_q <= '0;
      tailLen_q    <= '0;
      newBase_q    <= 1'b0;
      burstReq_q   <= 1'b0;
      tailReq_q    <= 1'b0;
      busy_q       <= 1'b0;
      frameDone_q  <= 1'b0;
`ifdef FRAME_SCHED_ABORT_EN
      abortFlag_q    <= 1'b0;
      frameAborted_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      burstCnt_q   <= burstCnt_d;
      lineCnt_q    <= lineCnt_d;
      tailDone_q   <= tailDone_d;
      gapCnt_q     <= gapCnt_d;
      vsize_q      <= vsize_d;
      lineBursts_q <= lineBursts_d;
      tailLen_q    <= tailLen_d;
      newBase_q    <= newBase_d;
      burstReq_q   <= burstReq_d;
      tailReq_q    <= tailReq_d;
      busy_q       <= busy_d;
      frameDone_q  <= frameDone_d;
`ifdef FRAME_SCHED_ABORT_EN
      abortFlag_q    <= abortFlag_d;
      frameAborted_q <= frameAborted_d;
`endif
    end
  end

  // Next-state logic: frame/line/burst sequencing, gap timing and acknowledge handling
  always_comb begin
    state_d      = state_q;
    burstCnt_d   = burstCnt_q;
    lineCnt_d    = lineCnt_q;
    tailDone_d   = tailDone_q;
    gapCnt_d     = gapCnt_q;
    vsize_d      = vsize_q;
    lineBursts_d = lineBursts_q;
    tailLen_d    = tailLen_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          vsize_d      = vsize;
          lineBursts_d = line_bursts;
          tailLen_d    = tail_len;
          burstCnt_d   = '0;
          lineCnt_d    = '0;
          tailDone_d   = 1'b0;
          state_d      = BASE;
        end
      end
      BASE: begin
        if (vsize_q == '0 || (lineBursts_q == '0 && tailLen_q == '0)) state_d = DONE;
        else if (lineBursts_q != '0)                                  state_d = BURST;
        else                                                          state_d = TAIL;
      end
      BURST: begin
        if (burst_ack) begin
          burstCnt_d = burstCnt_q + BSIZE'(1);
          gapCnt_d   = '0;
          state_d    = GAP;
        end
      end
      TAIL: begin
        if (tail_ack) begin
          tailDone_d = 1'b1;
          gapCnt_d   = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (gapCnt_q != GapLast) begin
          gapCnt_d = gapCnt_q + GW'(1);
        end else if (burstCnt_q < lineBursts_q) begin
          state_d = BURST;
        end else if (tailLen_q != '0 && !tailDone_q) begin
          state_d = TAIL;
        end else begin
          lineCnt_d  = lineNext;
          burstCnt_d = '0;
          tailDone_d = 1'b0;
          if (lineNext == vsize_q)       state_d = DONE;
          else if (lineBursts_q == '0)   state_d = TAIL;
          else                           state_d = BURST;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef FRAME_SCHED_ABORT_EN
    if (abortSeen) begin
      case (state_q)
        BASE, GAP: state_d = DONE;
        BURST:     if (burst_ack) state_d = DONE;
        TAIL:      if (tail_ack)  state_d = DONE;
        default:   ;
      endcase
    end
`endif
  end

`ifdef FRAME_SCHED_ABORT_EN
  // Abort is remembered from any working state so a held request can finish first
  always_comb begin
    abortSeen   = 1'b0;
    abortFlag_d = 1'b0;
    if (state_q == BASE || state_q == BURST || state_q == TAIL || state_q == GAP) begin
      abortSeen   = abortFlag_q | abort;
      abortFlag_d = abortSeen;
    end
  end
`endif

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    newBase_d   = (state_d == BASE);
    burstReq_d  = (state_d == BURST);
    tailReq_d   = (state_d == TAIL);
    busy_d      = (state_d != IDLE);
    frameDone_d = (state_d == DONE);
`ifdef FRAME_SCHED_ABORT_EN
    frameAborted_d = (state_d == DONE) && abortSeen;
`endif
  end

  assign new_base   = newBase_q;
  assign burst_req  = burstReq_q;
  assign tail_req   = tailReq_q;
  assign tail_beats = tailLen_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;
`ifdef FRAME_SCHED_ABORT_EN
  assign frame_aborted = frameAborted_q;
`endif

endmodule

// File: doc/frame_burst_sched.md
Name: frame_burst_sched

Overview:
Per-frame burst sequencer that drives the request side of the frame address generator. It issues new_base once per frame, then for every line issues N full-burst requests followed by an optional tail request, each as a level held until the AXI master acknowledges it. A minimum low gap follows every request so that the address generator's falling-edge detectors advance its address exactly once per request. Reports frame completion to the VDMA control logic.

Parameters:
LSIZE, 16, width of line-count (vsize) input and internal line counter
BSIZE, 12, width of bursts-per-line input and internal burst counter
TSIZE, 8, width of tail beat-count input/output
REQ_GAP, 3, cycles burst_req/tail_req stay low after each ack (minimum 1)

Ports:
clock  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle start pulse; ignored while busy
vsize  in  LSIZE  lines per frame; latched on accepted frame_start
line_bursts  in  BSIZE  full bursts per line; latched on accepted frame_start
tail_len  in  TSIZE  beats in the tail burst, 0 = no tail; latched on accepted frame_start
new_base  out  1  one-cycle pulse; address generator reloads its base address
burst_req  out  1  full-burst request level
burst_ack  in  1  master accepted the full burst
tail_req  out  1  tail-burst request level
tail_ack  in  1  master accepted the tail burst
tail_beats  out  TSIZE  latched tail_len, stable while busy
busy  out  1  high from the cycle after accepted frame_start to the frame_done cycle inclusive
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0, including tail_beats; counters 0. Reset mid-request drops burst_req/tail_req immediately. The master must also be reset.
- All outputs are registered.
- IDLE: frame_start=1 latches the three inputs and moves to BASE.
- BASE (1 cycle): new_base=1, busy=1. Next state:
  - vsize==0 or (line_bursts==0 and tail_len==0): go to DONE.
  - line_bursts!=0: go to BURST.
  - otherwise: go to TAIL.
- BURST: burst_req=1 until burst_ack is sampled high. The cycle after the ack, burst_req=0, burst_cnt increments, and the state moves to GAP.
- TAIL: tail_req=1 until tail_ack is sampled high. The state then moves to GAP and sets the line_end flag.
- GAP: both requests low for exactly REQ_GAP cycles, then route:
  - burst_cnt<line_bursts: go to BURST.
  - burst_cnt==line_bursts and tail_len!=0 and tail not yet issued this line: go to TAIL.
  - otherwise (line end): line_cnt increments and burst_cnt and the tail flag clear. If line_cnt (after increment) ==vsize, go to DONE. Otherwise start the next line with BURST, or TAIL if line_bursts==0.
- DONE (1 cycle): frame_done=1, busy=1, then go to IDLE. The earliest next frame_start is accepted in the IDLE cycle that follows.
- Handshake rules:
  - burst_ack and tail_ack are ignored unless the matching request is high.
  - An ack in the same cycle the request rises is valid, giving a 1-cycle request.
  - burst_req and tail_req are never high together.
  - Two requests are never closer than REQ_GAP low cycles.
- Counters compare at full width. line_bursts at maximum (2^BSIZE-1) must not wrap, so burst_cnt is BSIZE bits and is compared before the increment.
- Per frame, the exact request count is vsize*line_bursts burst_req rises plus vsize tail_req rises if tail_len!=0.
- Changes to vsize, line_bursts or tail_len while busy have no effect.

Optional Feature:
FRAME_SCHED_ABORT_EN
- Defined: adds input abort (1 bit) and output frame_aborted (1 bit, reset 0).
  - abort is sampled high in any busy state other than DONE.
  - A request already high stays high until its ack; the state then skips GAP routing.
  - From BASE or GAP, go to DONE the next cycle.
  - frame_aborted pulses together with frame_done.
  - abort in IDLE is ignored.
- Undefined: neither port exists and the frame always runs to completion.

Test Plan:
- vsize=2, line_bursts=3, tail_len=5, ack 2 cycles after each req rise: 1 new_base pulse, then 6 burst_req and 2 tail_req rises in order B,B,B,T,B,B,B,T. Every low gap is exactly 3 cycles. tail_beats=5. frame_done once, busy falls the cycle after.
- vsize=3, line_bursts=0, tail_len=4: exactly 3 tail_req rises and no burst_req. vsize=1, line_bursts=2, tail_len=0: exactly 2 burst_req rises and no tail_req.
- vsize=0 (and separately line_bursts=0, tail_len=0): new_base at cycle 1, frame_done at cycle 2, no requests, busy high for 2 cycles.
- Ack asserted continuously, and ack pulsed while the request is low: each request lasts 1 cycle, spurious acks have no effect, and counts match the formula. A second frame_start while busy is ignored.
- rst pulsed while burst_req=1 mid-frame: all outputs 0 immediately. A new frame_start then begins a fresh frame with a new_base pulse.
- FRAME_SCHED_ABORT_EN: abort during GAP ends with frame_done and frame_aborted in the same cycle after 1 cycle. Abort while burst_req is high with ack delayed 5 cycles keeps the request held until the ack, then DONE follows.
